riscv_result_checker: RTL and testbench
=======================================

// Module: riscv_result_checker
// PURPOSE
// - Synthesizable self-check stage directly downstream of RISCV_TOP; consumes NUM_INST, OUTPUT_PORT and HALT.
// - Holds a loadable table of (instruction-count milestone, expected OUTPUT_PORT) pairs.
// - Checks each milestone in order and reports PASS/FAIL, the failing entry, cycle count and timeout.
// - Replaces bench-side checking loops, so board/FPGA runs give the same verdict as simulation.
// PARAMETERS
// - NUM_TEST  21       table depth (entries)
// - IDX_W     5        table index width, clog2(NUM_TEST)
// - DWIDTH    32       NUM_INST / OUTPUT_PORT / answer width
// - TIMEOUT   1000000  RUN cycles before forced FAIL
// PORTS
// - CLK          in   1       clock, rising edge
// - RSTn         in   1       synchronous, active-low reset
// - CFG_WE       in   1       table write strobe (honoured in IDLE/PASS/FAIL only)
// - CFG_IDX      in   IDX_W   table write index; writes to index >= NUM_TEST are ignored
// - CFG_NUM_INST in   DWIDTH  milestone instruction count
// - CFG_ANS      in   DWIDTH  expected OUTPUT_PORT at that milestone
// - CFG_LEN      in   IDX_W+1 number of active entries, sampled at START, clamped to NUM_TEST
// - START        in   1       begin/restart a check run
// - NUM_INST     in   DWIDTH  retired-instruction count from core
// - OUTPUT_PORT  in   DWIDTH  core result port
// - HALT         in   1       core halt
// - DONE         out  1       verdict valid (PASS or FAIL state)
// - PASS         out  1       run passed
// - FAIL         out  1       run failed
// - TIMED_OUT    out  1       failure cause was timeout
// - FAIL_IDX     out  IDX_W   entry index at failure
// - FAIL_VAL     out  DWIDTH  OUTPUT_PORT captured at failure
// - PASS_CNT     out  IDX_W+1 entries passed so far
// - CYCLE        out  DWIDTH  RUN cycle count
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; ptr=0; len=0. Table contents are NOT cleared.
// - States: IDLE, RUN, PASS, FAIL.
//   - START in IDLE/PASS/FAIL -> RUN next cycle; clears ptr, PASS_CNT, CYCLE, FAIL_*, TIMED_OUT; latches len.
//   - START in RUN is ignored.
// - RUN, every cycle (priority order, all registered, 1-cycle latency):
//   1. NUM_INST == tbl[ptr].num_inst && ptr < len:
//      - OUTPUT_PORT == ans -> ptr++, PASS_CNT++.
//      - mismatch -> FAIL; FAIL_IDX=ptr; FAIL_VAL=OUTPUT_PORT.
//   2. NUM_INST > tbl[ptr].num_inst && ptr < len (milestone skipped) -> FAIL; FAIL_IDX=ptr; FAIL_VAL=OUTPUT_PORT.
//   3. HALT -> PASS (see CONFIGURATION for unchecked entries).
//      - Match and HALT in the same cycle: the compare is done first; a mismatch wins and the result is FAIL.
//   4. CYCLE == TIMEOUT-1 with no other event -> FAIL; TIMED_OUT=1; FAIL_IDX=ptr.
//   5. Otherwise CYCLE++.
// - len == 0: only HALT and timeout are evaluated.
// - Milestones must be strictly ascending; equal or descending entries are a configuration error (not checked).
// - PASS/FAIL are sticky until START or reset; DONE = PASS|FAIL.
// - CYCLE holds its value at the verdict.
// - Reset mid-RUN: returns to IDLE immediately; the table is kept and can be rerun without reload.
// - All compares are unsigned, full DWIDTH.
// CONFIGURATION
// - Macro CHK_STRICT_HALT_EN.
// - Defined: HALT with ptr < len -> FAIL; FAIL_IDX=ptr; FAIL_VAL=OUTPUT_PORT.
// - Undefined: HALT -> PASS regardless of ptr; unchecked entries are visible only as PASS_CNT < len.
// STRUCTURE
// - Package riscv_chk_pkg:
//   - chk_state_t enum (IDLE, RUN, PASS, FAIL)
//   - chk_entry_t struct {num_inst, ans}
//   - default NUM_TEST/DWIDTH/TIMEOUT constants
// - Sub-module chk_table:
//   - NUM_TEST x chk_entry_t register array
//   - synchronous write port, combinational read at ptr
//   - no reset on contents
// - FSM, pointer, counters and capture registers stay in riscv_result_checker.
// TESTING
// - Load {1,5},{2,0},{3,1}; len=3; START; drive NUM_INST 1..3 with OUTPUT_PORT 5,0,1; HALT at 3
//   -> PASS=1, PASS_CNT=3, FAIL=0.
// - Same table; OUTPUT_PORT=4 at NUM_INST=1 -> FAIL next cycle, FAIL_IDX=0, FAIL_VAL=4, DONE=1.
// - NUM_INST jumps 1->3 (entry {2,0} skipped) -> FAIL, FAIL_IDX=1.
// - len=3; HALT after NUM_INST=2 -> PASS with PASS_CNT=2 (macro off); FAIL, FAIL_IDX=2 (CHK_STRICT_HALT_EN).
// - TIMEOUT=16, len=1; NUM_INST held at 0 -> FAIL, TIMED_OUT=1, CYCLE=15; then START -> RUN, counters 0.
// - RSTn low mid-RUN for 1 cycle -> all outputs 0 and IDLE; START without reload -> table entries still checked.

Source files
------------

// File: rtl/riscv_chk_pkg.sv
// riscv_chk_pkg: shared types and default sizing for the RISC-V result checker
package riscv_chk_pkg;
  localparam int CHK_NUM_TEST = 21;
  localparam int CHK_IDX_W = 5;
  localparam int CHK_DWIDTH = 32;
  localparam int CHK_TIMEOUT = 1000000;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} chk_state_t;
  typedef struct packed {
    logic [CHK_DWIDTH-1:0] num_inst;
    logic [CHK_DWIDTH-1:0] ans;
  } chk_entry_t;
endpackage

// File: rtl/chk_table.sv
// chk_table: milestone/answer register array, sync write, combinational read, contents survive reset
module chk_table
  import riscv_chk_pkg::*;
#(
  parameter int NUM_TEST = CHK_NUM_TEST,
  parameter int IDX_W = CHK_IDX_W
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  chk_entry_t       wr_entry,
  input  logic [IDX_W-1:0] rd_idx,
  output chk_entry_t       rd_entry
);
  chk_entry_t mem [NUM_TEST];
  // writes beyond the table depth are dropped
  always_ff @(posedge CLK)
    if (we && 32'(wr_idx) < NUM_TEST) mem[wr_idx] <= wr_entry;
  assign rd_entry = (32'(rd_idx) < NUM_TEST) ? mem[rd_idx] : '0;
endmodule

// File: rtl/riscv_result_checker.sv
// riscv_result_checker: in-order milestone checker for RISCV_TOP results (option: CHK_STRICT_HALT_EN)
module riscv_result_checker
  import riscv_chk_pkg::*;
#(
  parameter int NUM_TEST = CHK_NUM_TEST,
  parameter int IDX_W = CHK_IDX_W,
  parameter int DWIDTH = CHK_DWIDTH,
  parameter int TIMEOUT = CHK_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              CFG_WE,
  input  logic [IDX_W-1:0]  CFG_IDX,
  input  logic [DWIDTH-1:0] CFG_NUM_INST,
  input  logic [DWIDTH-1:0] CFG_ANS,
  input  logic [IDX_W:0]    CFG_LEN,
  input  logic              START,
  input  logic [DWIDTH-1:0] NUM_INST,
  input  logic [DWIDTH-1:0] OUTPUT_PORT,
  input  logic              HALT,
  output logic              DONE,
  output logic              PASS,
  output logic              FAIL,
  output logic              TIMED_OUT,
  output logic [IDX_W-1:0]  FAIL_IDX,
  output logic [DWIDTH-1:0] FAIL_VAL,
  output logic [IDX_W:0]    PASS_CNT,
  output logic [DWIDTH-1:0] CYCLE
);
  chk_state_t state;
  logic [IDX_W:0] ptr, len;
  chk_entry_t ent, wr_ent;
  logic active, hit, ok, skip;
  assign wr_ent = {CFG_NUM_INST, CFG_ANS};
  chk_table #(.NUM_TEST(NUM_TEST), .IDX_W(IDX_W)) u_table (
    .CLK(CLK),
    .we(CFG_WE && state != ST_RUN),
    .wr_idx(CFG_IDX),
    .wr_entry(wr_ent),
    .rd_idx(ptr[IDX_W-1:0]),
    .rd_entry(ent)
  );
`ifdef CHK_STRICT_HALT_EN
  logic [IDX_W:0] halt_ptr;
  logic halt_short;
`endif
  // milestone compare against the entry under the pointer
  always_comb begin
    active = ptr < len;
    hit = active && NUM_INST == ent.num_inst;
    ok = OUTPUT_PORT == ent.ans;
    skip = active && NUM_INST > ent.num_inst;
`ifdef CHK_STRICT_HALT_EN
    halt_ptr = hit ? ptr + 1'b1 : ptr;
    halt_short = halt_ptr < len;
`endif
  end
  // run FSM: compare failure beats halt, halt beats timeout; the pointer doubles as the pass count
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state <= ST_IDLE;
      ptr <= '0;
      len <= '0;
      CYCLE <= '0;
      TIMED_OUT <= 1'b0;
      FAIL_IDX <= '0;
      FAIL_VAL <= '0;
    end else if (state != ST_RUN) begin
      if (START) begin
        state <= ST_RUN;
        ptr <= '0;
        CYCLE <= '0;
        TIMED_OUT <= 1'b0;
        FAIL_IDX <= '0;
        FAIL_VAL <= '0;
        len <= (CFG_LEN > (IDX_W+1)'(NUM_TEST)) ? (IDX_W+1)'(NUM_TEST) : CFG_LEN;
      end
    end else if ((hit && !ok) || skip) begin
      state <= ST_FAIL;
      FAIL_IDX <= ptr[IDX_W-1:0];
      FAIL_VAL <= OUTPUT_PORT;
    end else begin
      if (hit) ptr <= ptr + 1'b1;
      if (HALT) begin
`ifdef CHK_STRICT_HALT_EN
        state <= halt_short ? ST_FAIL : ST_PASS;
        FAIL_IDX <= halt_short ? halt_ptr[IDX_W-1:0] : FAIL_IDX;
        FAIL_VAL <= halt_short ? OUTPUT_PORT : FAIL_VAL;
`else
        state <= ST_PASS;
`endif
      end else if (!hit && CYCLE == DWIDTH'(TIMEOUT - 1)) begin
        state <= ST_FAIL;
        TIMED_OUT <= 1'b1;
        FAIL_IDX <= ptr[IDX_W-1:0];
      end else if (!hit) CYCLE <= CYCLE + 1'b1;
    end
  end
  assign PASS = state == ST_PASS;
  assign FAIL = state == ST_FAIL;
  assign DONE = PASS | FAIL;
  assign PASS_CNT = ptr;
endmodule

// File: tb/tb_riscv_result_checker.sv
// tb_riscv_result_checker: directed self-checking bench for riscv_result_checker
module tb_riscv_result_checker;
  logic clk = 1'b0;
  logic rstn, cfg_we, start, halt;
  logic [4:0] cfg_idx;
  logic [5:0] cfg_len;
  logic [31:0] cfg_num_inst, cfg_ans, num_inst, out_port;
  logic done, pass, fail, timed_out;
  logic [4:0] fail_idx;
  logic [31:0] fail_val, cycle;
  logic [5:0] pass_cnt;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  riscv_result_checker #(.NUM_TEST(21), .IDX_W(5), .DWIDTH(32), .TIMEOUT(16)) dut (
    .CLK(clk), .RSTn(rstn), .CFG_WE(cfg_we), .CFG_IDX(cfg_idx),
    .CFG_NUM_INST(cfg_num_inst), .CFG_ANS(cfg_ans), .CFG_LEN(cfg_len),
    .START(start), .NUM_INST(num_inst), .OUTPUT_PORT(out_port), .HALT(halt),
    .DONE(done), .PASS(pass), .FAIL(fail), .TIMED_OUT(timed_out),
    .FAIL_IDX(fail_idx), .FAIL_VAL(fail_val), .PASS_CNT(pass_cnt), .CYCLE(cycle)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input int idx, input int n, input int a);
    cfg_we = 1'b1; cfg_idx = 5'(idx); cfg_num_inst = 32'(n); cfg_ans = 32'(a);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic run(input int l);
    start = 1'b1; cfg_len = 6'(l);
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; cfg_we = 0; start = 0; halt = 0; cfg_idx = 0; cfg_len = 0;
    cfg_num_inst = 0; cfg_ans = 0; num_inst = 0; out_port = 0;
    step(); step();
    tests++; if ({done, pass, fail, timed_out} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b exp 0000", {done, pass, fail, timed_out}); end
    tests++; if (pass_cnt !== 6'd0) begin fails++; $display("FAIL reset_pass_cnt got %0d exp 0", pass_cnt); end
    tests++; if (cycle !== 32'd0) begin fails++; $display("FAIL reset_cycle got %0d exp 0", cycle); end
    tests++; if ({fail_idx, fail_val} !== 37'd0) begin fails++; $display("FAIL reset_fail_info got %0h exp 0", {fail_idx, fail_val}); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_pass();
    load(0, 1, 5); load(1, 2, 0); load(2, 3, 1);
    run(3);
    num_inst = 1; out_port = 5; step();
    tests++; if (pass_cnt !== 6'd1 || done !== 1'b0) begin fails++; $display("FAIL pass_first got cnt=%0d done=%b exp cnt=1 done=0", pass_cnt, done); end
    num_inst = 2; out_port = 0; step();
    num_inst = 3; out_port = 1; halt = 1; step();
    halt = 0; num_inst = 0; out_port = 0;
    tests++; if ({pass, fail, done} !== 3'b101) begin fails++; $display("FAIL pass_verdict got p/f/d=%b exp 101", {pass, fail, done}); end
    tests++; if (pass_cnt !== 6'd3) begin fails++; $display("FAIL pass_cnt got %0d exp 3", pass_cnt); end
    step(); step();
    tests++; if (pass !== 1'b1) begin fails++; $display("FAIL pass_sticky got %b exp 1", pass); end
  endtask

  task automatic test_mismatch();
    run(3);
    num_inst = 1; out_port = 4; step();
    num_inst = 0; out_port = 0;
    tests++; if ({fail, done, pass} !== 3'b110) begin fails++; $display("FAIL mismatch_verdict got f/d/p=%b exp 110", {fail, done, pass}); end
    tests++; if (fail_idx !== 5'd0 || fail_val !== 32'd4) begin fails++; $display("FAIL mismatch_info got idx=%0d val=%0d exp idx=0 val=4", fail_idx, fail_val); end
    tests++; if (cycle !== 32'd0 || timed_out !== 1'b0) begin fails++; $display("FAIL mismatch_cycle got cyc=%0d to=%b exp 0 0", cycle, timed_out); end
  endtask

  task automatic test_skip();
    run(3);
    cfg_we = 1; cfg_idx = 0; cfg_num_inst = 1; cfg_ans = 9;
    num_inst = 1; out_port = 5; step();
    cfg_we = 0;
    tests++; if (pass_cnt !== 6'd1 || fail !== 1'b0) begin fails++; $display("FAIL run_write_ignored got cnt=%0d fail=%b exp 1 0", pass_cnt, fail); end
    num_inst = 3; out_port = 8; step();
    num_inst = 0; out_port = 0;
    tests++; if (fail !== 1'b1 || fail_idx !== 5'd1 || fail_val !== 32'd8) begin fails++; $display("FAIL skip got fail=%b idx=%0d val=%0d exp 1 1 8", fail, fail_idx, fail_val); end
  endtask

  task automatic test_early_halt();
    run(3);
    num_inst = 1; out_port = 5; step();
    num_inst = 2; out_port = 0; step();
    out_port = 6; halt = 1; step();
    halt = 0; num_inst = 0; out_port = 0;
`ifdef CHK_STRICT_HALT_EN
    tests++; if (fail !== 1'b1 || fail_idx !== 5'd2 || fail_val !== 32'd6) begin fails++; $display("FAIL early_halt got fail=%b idx=%0d val=%0d exp 1 2 6", fail, fail_idx, fail_val); end
`else
    tests++; if (pass !== 1'b1 || fail !== 1'b0) begin fails++; $display("FAIL early_halt got pass=%b fail=%b exp 1 0", pass, fail); end
`endif
    tests++; if (pass_cnt !== 6'd2) begin fails++; $display("FAIL early_halt_cnt got %0d exp 2", pass_cnt); end
    run(0);
    num_inst = 5; out_port = 7; step();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL len0_running got done=%b exp 0", done); end
    halt = 1; step();
    halt = 0; num_inst = 0; out_port = 0;
    tests++; if (pass !== 1'b1 || pass_cnt !== 6'd0) begin fails++; $display("FAIL len0_halt got pass=%b cnt=%0d exp 1 0", pass, pass_cnt); end
  endtask

  task automatic test_timeout();
    run(1);
    for (int i = 0; i < 15; i++) step();
    tests++; if (done !== 1'b0 || cycle !== 32'd15) begin fails++; $display("FAIL pre_timeout got done=%b cyc=%0d exp 0 15", done, cycle); end
    step();
    tests++; if ({fail, timed_out} !== 2'b11 || cycle !== 32'd15 || fail_idx !== 5'd0) begin fails++; $display("FAIL timeout got f/to=%b cyc=%0d idx=%0d exp 11 15 0", {fail, timed_out}, cycle, fail_idx); end
    run(1);
    tests++; if (done !== 1'b0 || timed_out !== 1'b0 || cycle !== 32'd0 || pass_cnt !== 6'd0) begin fails++; $display("FAIL restart got done=%b to=%b cyc=%0d cnt=%0d exp 0 0 0 0", done, timed_out, cycle, pass_cnt); end
  endtask

  task automatic test_reset_mid_run();
    num_inst = 1; out_port = 5; step();
    num_inst = 0; out_port = 0;
    tests++; if (pass_cnt !== 6'd1) begin fails++; $display("FAIL midrun_cnt got %0d exp 1", pass_cnt); end
    rstn = 0; step();
    rstn = 1;
    tests++; if ({done, pass, fail, timed_out} !== 4'b0 || pass_cnt !== 6'd0 || cycle !== 32'd0) begin fails++; $display("FAIL midrun_reset got flags=%b cnt=%0d cyc=%0d exp 0 0 0", {done, pass, fail, timed_out}, pass_cnt, cycle); end
    step(); step();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_idle got done=%b exp 0", done); end
    run(3);
    num_inst = 1; out_port = 5; step();
    num_inst = 2; out_port = 0; step();
    num_inst = 3; out_port = 1; halt = 1; step();
    halt = 0; num_inst = 0; out_port = 0;
    tests++; if (pass !== 1'b1 || pass_cnt !== 6'd3) begin fails++; $display("FAIL table_kept got pass=%b cnt=%0d exp 1 3", pass, pass_cnt); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_skip();
    test_early_halt();
    test_timeout();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
